bit_reg_arbiter: RTL

BIT_REG_ARBITER -- requirements
Module: bit_reg_arbiter

---
 rtl/bit_reg_arbiter_pkg.sv | 22 ++
 rtl/bit_reg_arbiter_if.sv | 45 ++++
 rtl/bit_reg_arb_pick.sv | 37 +++
 rtl/bit_reg_arbiter.sv | 101 ++++++++++
 4 files changed

// File: rtl/bit_reg_arbiter_pkg.sv
// Shared types and constants for the bit-register write arbiter.
// The arbitration policy is selected by the BITREG_ARB_RR_EN macro in bit_reg_arb_pick.
package bit_reg_arbiter_pkg;

  localparam int BITREG_SEL_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    ACK   = 2'd2
  } arb_state_t;

  typedef enum logic {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

  function automatic req_id_t other_id(input req_id_t id);
    return (id == REQ_A) ? REQ_B : REQ_A;
  endfunction

endpackage

// File: rtl/bit_reg_arbiter_if.sv
// Bundle of the two requester handshakes, write-protect mask, error flag
// and demux drive lines shared between the arbiter and its environment.
interface bit_reg_arbiter_if
  import bit_reg_arbiter_pkg::*;
#(
  parameter int SEL_W = BITREG_SEL_W
);

  logic                    a_req;
  logic [SEL_W-1:0]        a_sel;
  logic                    a_data;
  logic                    a_ack;

  logic                    b_req;
  logic [SEL_W-1:0]        b_sel;
  logic                    b_data;
  logic                    b_ack;

  logic [(2**SEL_W)-1:0]   wp_mask;
  logic                    err;

  logic [SEL_W-1:0]        dmx_sel;
  logic                    dmx_in;
  logic                    dmx_we;
  logic                    busy;

  // The arbiter block itself
  modport slave (
    input  a_req, a_sel, a_data,
    input  b_req, b_sel, b_data,
    input  wp_mask,
    output a_ack, b_ack, err,
    output dmx_sel, dmx_in, dmx_we, busy
  );

  // Requesters plus the external demux, seen from outside the arbiter
  modport master (
    output a_req, a_sel, a_data,
    output b_req, b_sel, b_data,
    output wp_mask,
    input  a_ack, b_ack, err,
    input  dmx_sel, dmx_in, dmx_we, busy
  );

endinterface

// File: rtl/bit_reg_arb_pick.sv
// Combinational 2-way arbiter. BITREG_ARB_RR_EN defined: alternate on conflict
// using the last grant; undefined: fixed priority, A always wins.
module bit_reg_arb_pick
  import bit_reg_arbiter_pkg::*;
(
  input  logic    req_a,
  input  logic    req_b,
  input  req_id_t last,
  output req_id_t grant_id,
  output logic    valid
);

`ifdef BITREG_ARB_RR_EN
  always_comb begin
    valid    = req_a | req_b;
    grant_id = REQ_A;
    if (req_a && req_b) begin
      grant_id = other_id(last);
    end else if (req_b) begin
      grant_id = REQ_B;
    end
  end
`else
  // History is irrelevant under fixed priority
  logic unused_last;
  assign unused_last = last;

  always_comb begin
    valid    = req_a | req_b;
    grant_id = REQ_A;
    if (!req_a && req_b) begin
      grant_id = REQ_B;
    end
  end
`endif

endmodule

// File: rtl/bit_reg_arbiter.sv
// Arbitrates single-bit writes from two requesters onto an external bit-register
// demux, honouring a per-bit write-protect mask. Policy set by BITREG_ARB_RR_EN.
module bit_reg_arbiter
  import bit_reg_arbiter_pkg::*;
#(
  parameter int SEL_W = BITREG_SEL_W
)(
  input  logic               clk,
  input  logic               rst,
  bit_reg_arbiter_if.slave   bus
);

  arb_state_t        state;
  req_id_t           last_grant;
  req_id_t           lat_id;
  logic              lat_prot;

  logic [SEL_W-1:0]  dmx_sel_q;
  logic              dmx_in_q;
  logic              dmx_we_q;
  logic              a_ack_q;
  logic              b_ack_q;
  logic              err_q;
  logic              busy_q;

  req_id_t           pick_id;
  logic              pick_valid;
  logic [SEL_W-1:0]  win_sel;
  logic              win_data;

  bit_reg_arb_pick u_pick (
    .req_a    (bus.a_req),
    .req_b    (bus.b_req),
    .last     (last_grant),
    .grant_id (pick_id),
    .valid    (pick_valid)
  );

  assign win_sel  = (pick_id == REQ_A) ? bus.a_sel  : bus.b_sel;
  assign win_data = (pick_id == REQ_A) ? bus.a_data : bus.b_data;

  // The demux select/data registers double as the latched request, so they
  // naturally hold their value after the write completes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= REQ_B;
      lat_id     <= REQ_A;
      lat_prot   <= 1'b0;
      dmx_sel_q  <= '0;
      dmx_in_q   <= 1'b0;
      dmx_we_q   <= 1'b0;
      a_ack_q    <= 1'b0;
      b_ack_q    <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      dmx_we_q <= 1'b0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      err_q    <= 1'b0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            state      <= WRITE;
            busy_q     <= 1'b1;
            last_grant <= pick_id;
            lat_id     <= pick_id;
            lat_prot   <= bus.wp_mask[win_sel];
            dmx_sel_q  <= win_sel;
            dmx_in_q   <= win_data;
            dmx_we_q   <= ~bus.wp_mask[win_sel];
          end
        end
        WRITE: begin
          state   <= ACK;
          a_ack_q <= (lat_id == REQ_A);
          b_ack_q <= (lat_id == REQ_B);
          err_q   <= lat_prot;
        end
        ACK: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dmx_sel = dmx_sel_q;
  assign bus.dmx_in  = dmx_in_q;
  assign bus.dmx_we  = dmx_we_q;
  assign bus.a_ack   = a_ack_q;
  assign bus.b_ack   = b_ack_q;
  assign bus.err     = err_q;
  assign bus.busy    = busy_q;

endmodule
